// File: rtl/fixed_pkg.sv
// Shared types and helpers for the fixed-point stream units.
// Saturating add is evaluated at a fixed maximum width and clamped to the caller's width.
package fixed_pkg;

   localparam int unsigned ACC_MAX_W = 64;
   localparam int unsigned SUM_W     = ACC_MAX_W + 1;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   typedef struct packed {
      logic                 ovf;
      logic [ACC_MAX_W-1:0] sum;
   } sat_res_t;

   // Operands must already be sign-extended from a w-bit signed range (w <= ACC_MAX_W).
   function automatic sat_res_t sat_add(input logic signed [ACC_MAX_W-1:0] acc,
                                        input logic signed [ACC_MAX_W-1:0] ext,
                                        input int unsigned                 w);
      logic signed [SUM_W-1:0] sum;
      logic signed [SUM_W-1:0] hi;
      logic signed [SUM_W-1:0] lo;
      sat_res_t                res;
      sum     = SUM_W'(acc) + SUM_W'(ext);
      hi      = (SUM_W'(1) <<< (w - 1)) - SUM_W'(1);
      lo      = -hi - SUM_W'(1);
      res.ovf = 1'b0;
      res.sum = ACC_MAX_W'(sum);
      if (sum > hi) begin
         res.ovf = 1'b1;
         res.sum = ACC_MAX_W'(hi);
      end else if (sum < lo) begin
         res.ovf = 1'b1;
         res.sum = ACC_MAX_W'(lo);
      end
      return res;
   endfunction

endpackage

// File: rtl/fixed_stream_acc.sv
// Accumulates a programmable-length vector of signed fixed-point elements into one
// saturated sum, presented on a registered valid/ready output.
module fixed_stream_acc
   import fixed_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ACC_WIDTH = 48,
   parameter int unsigned LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [LEN_WIDTH-1:0] cfg_len,
   input  logic                 in_vld,
   input  logic [WIDTH-1:0]     in_dat,
   output logic                 in_rdy,
   output logic                 out_vld,
   output logic [ACC_WIDTH-1:0] out_dat,
   output logic                 out_ovf,
   input  logic                 out_rdy
);

   state_e                      state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]        len_q, len_d;
   logic                        ovf_q, ovf_d;
   logic                        out_vld_q, out_vld_d;
   logic [ACC_WIDTH-1:0]        out_dat_q, out_dat_d;
   logic                        out_ovf_q, out_ovf_d;

   logic                        hs_c;
   logic                        last_c;
   logic [LEN_WIDTH-1:0]        eff_len_c;
   sat_res_t                    sat_c;
   logic signed [ACC_WIDTH-1:0] sum_c;
   logic                        sticky_c;

   assign in_rdy  = (state_q == ST_ACC);
   assign out_vld = out_vld_q;
   assign out_dat = out_dat_q;
   assign out_ovf = out_ovf_q;

   assign hs_c = in_vld && in_rdy;

   // Length is taken from cfg_len on the first element, from len_q afterwards.
   assign eff_len_c = (cnt_q == '0) ? ((cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len) : len_q;
   assign last_c    = (cnt_q == (eff_len_c - LEN_WIDTH'(1)));

   assign sat_c    = sat_add(ACC_MAX_W'(acc_q), ACC_MAX_W'($signed(in_dat)), ACC_WIDTH);
   assign sum_c    = ACC_WIDTH'(sat_c.sum);
   assign sticky_c = ovf_q | sat_c.ovf;

   // Next-state logic for the collect/hold FSM and datapath.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      ovf_d     = ovf_q;
      out_vld_d = out_vld_q;
      out_dat_d = out_dat_q;
      out_ovf_d = out_ovf_q;
      case (state_q)
         ST_ACC: begin
            if (hs_c) begin
               if (cnt_q == '0) begin
                  len_d = eff_len_c;
               end
               if (last_c) begin
                  out_dat_d = sum_c;
                  out_ovf_d = sticky_c;
                  out_vld_d = 1'b1;
                  state_d   = ST_HOLD;
                  acc_d     = '0;
                  cnt_d     = '0;
                  ovf_d     = 1'b0;
               end else begin
                  acc_d = sum_c;
                  cnt_d = cnt_q + LEN_WIDTH'(1);
                  ovf_d = sticky_c;
               end
            end
         end
         ST_HOLD: begin
            if (out_rdy) begin
               out_vld_d = 1'b0;
               state_d   = ST_ACC;
            end
         end
         default: state_d = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ACC;
         acc_q     <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         ovf_q     <= 1'b0;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         ovf_q     <= ovf_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
         out_ovf_q <= out_ovf_d;
      end
   end

endmodule

// File: tb/tb_fixed_stream_acc.sv
// Scoreboard bench: a 48-bit and a 32-bit accumulator share one stimulus stream and are
// checked against a saturating reference computed per vector with plain integer arithmetic.
module tb_fixed_stream_acc;

   localparam int W  = 32;
   localparam int AW = 48;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [LW-1:0] cfg_len;
   logic          in_vld;
   logic [W-1:0]  in_dat;
   logic          in_rdy, in_rdy32;
   logic          out_vld, out_vld32;
   logic [AW-1:0] out_dat;
   logic [31:0]   out_dat32;
   logic          out_ovf, out_ovf32;
   logic          out_rdy;

   typedef struct {
      logic [AW-1:0] d48;
      logic          o48;
      logic [31:0]   d32;
      logic          o32;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] vq[$];
   int           checks   = 0;
   int           failures = 0;
   int           rdy_mode = 0;

   always #5 clk = ~clk;

   fixed_stream_acc #(.WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .in_vld(in_vld), .in_dat(in_dat),
      .in_rdy(in_rdy), .out_vld(out_vld), .out_dat(out_dat), .out_ovf(out_ovf),
      .out_rdy(out_rdy)
   );

   fixed_stream_acc #(.WIDTH(W), .ACC_WIDTH(32), .LEN_WIDTH(LW)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .in_vld(in_vld), .in_dat(in_dat),
      .in_rdy(in_rdy32), .out_vld(out_vld32), .out_dat(out_dat32), .out_ovf(out_ovf32),
      .out_rdy(out_rdy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic longint clamp(input longint v, input int w, inout logic ovf);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) begin
         ovf = 1'b1;
         return hi;
      end
      if (v < lo) begin
         ovf = 1'b1;
         return lo;
      end
      return v;
   endfunction

   // Drives the elements in vq; vq must hold exactly the effective vector length.
   task automatic send_vec(input int cfg, input int chg_at, input int chg_cfg,
                           input int abort_after, input bit gaps);
      longint a48 = 0;
      longint a32 = 0;
      logic   o48 = 1'b0;
      logic   o32 = 1'b0;
      int     tmo;
      exp_t   e;
      cfg_len = LW'(cfg);
      for (int i = 0; i < vq.size(); i++) begin
         if (i == abort_after) return;
         if (i == chg_at) cfg_len = LW'(chg_cfg);
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         in_vld = 1'b1;
         in_dat = vq[i];
         tmo = 0;
         while (!in_rdy && tmo < 100) begin
            @(negedge clk);
            tmo++;
         end
         if (!in_rdy) begin
            chk("in_rdy_timeout", 64'(in_rdy), 64'(1));
            in_vld = 1'b0;
            return;
         end
         @(posedge clk);
         a48 = clamp(a48 + longint'($signed(vq[i])), AW, o48);
         a32 = clamp(a32 + longint'($signed(vq[i])), 32, o32);
         if (i == vq.size() - 1) begin
            e.d48 = AW'(a48);
            e.o48 = o48;
            e.d32 = 32'(a32);
            e.o32 = o32;
            exp_q.push_back(e);
         end
         @(negedge clk);
         in_vld = 1'b0;
         in_dat = $urandom;
      end
      chk("latency_out_vld", 64'(out_vld), 64'(1));
      chk("latency_in_rdy", 64'(in_rdy), 64'(0));
   endtask

   // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
   initial begin
      out_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom % 2);
      end
   end

   // Monitor: pops one expectation per presented sum and checks it until accepted.
   initial begin
      exp_t cur;
      bit   holding  = 1'b0;
      bit   acc_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            holding  = 1'b0;
            acc_prev = 1'b0;
         end else begin
            if (acc_prev) begin
               chk("after_accept_out_vld", 64'(out_vld), 64'(0));
               chk("after_accept_in_rdy", 64'(in_rdy), 64'(1));
               chk("after_accept_dat_held", 64'(out_dat), 64'(cur.d48));
               acc_prev = 1'b0;
            end
            chk("vld_match_32", 64'(out_vld32), 64'(out_vld));
            if (out_vld) begin
               chk("hold_in_rdy", 64'(in_rdy), 64'(0));
               if (!holding) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_out_vld", 64'(out_vld), 64'(0));
                  end else begin
                     cur     = exp_q.pop_front();
                     holding = 1'b1;
                  end
               end
               if (holding) begin
                  chk("out_dat", 64'(out_dat), 64'(cur.d48));
                  chk("out_ovf", 64'(out_ovf), 64'(cur.o48));
                  chk("out_dat32", 64'(out_dat32), 64'(cur.d32));
                  chk("out_ovf32", 64'(out_ovf32), 64'(cur.o32));
                  if (out_rdy) begin
                     holding  = 1'b0;
                     acc_prev = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tmo;
      int cfg;
      int n;
      rst_n   = 1'b0;
      cfg_len = '0;
      in_vld  = 1'b0;
      in_dat  = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_rdy", 64'(in_rdy), 64'(1));
      chk("rst_out_vld", 64'(out_vld), 64'(0));
      chk("rst_out_dat", 64'(out_dat), 64'(0));
      chk("rst_out_ovf", 64'(out_ovf), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      vq = '{32'd5, 32'hFFFF_FFFD, 32'd10, 32'd1};
      send_vec(4, -1, 0, -1, 1'b0);

      rdy_mode = 2;
      send_vec(4, -1, 0, -1, 1'b0);
      repeat (5) @(negedge clk);
      rdy_mode = 0;

      vq = '{32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF};
      send_vec(3, -1, 0, -1, 1'b0);

      vq = '{32'hFFFF_FFF9};
      send_vec(0, -1, 0, -1, 1'b0);

      vq = '{32'd1, 32'd2, 32'd3};
      send_vec(3, 1, 2, -1, 1'b0);
      vq = '{32'd4, 32'd5};
      send_vec(2, -1, 0, -1, 1'b0);

      vq = '{32'd1, 32'd1, 32'd1, 32'd1};
      send_vec(4, -1, 0, 2, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out_vld", 64'(out_vld), 64'(0));
      chk("midrst_out_dat", 64'(out_dat), 64'(0));
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("postrst_out_vld", 64'(out_vld), 64'(0));
      send_vec(4, -1, 0, -1, 1'b0);

      rdy_mode = 1;
      for (int v = 0; v < 40; v++) begin
         cfg = $urandom_range(0, 6);
         n   = (cfg == 0) ? 1 : cfg;
         vq.delete();
         for (int k = 0; k < n; k++) begin
            case ($urandom % 4)
               0:       vq.push_back(32'h7FFF_FFFF);
               1:       vq.push_back(32'h8000_0000);
               default: vq.push_back(32'($urandom));
            endcase
         end
         send_vec(cfg, 1, $urandom_range(0, 7), -1, 1'b1);
      end

      rdy_mode = 0;
      tmo = 0;
      while ((exp_q.size() != 0 || out_vld) && tmo < 100) begin
         @(negedge clk);
         tmo++;
      end
      @(negedge clk);
      chk("drain_queue", 64'(exp_q.size()), 64'(0));
      chk("drain_out_vld", 64'(out_vld), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fixed_stream_acc.md
Name: fixed_stream_acc

Overview:
- Stream consumer ("reader") for the fixed-point valid/ready result streams produced by the fixed_sub/fixed_add arithmetic units.
- Accepts signed WIDTH-bit fixed-point elements with full valid/ready backpressure and accumulates a vector of programmable length.
- Emits one saturated ACC_WIDTH-bit sum per vector on a registered valid/ready output; sits between the elementwise arithmetic units and the downstream scheduler/writeback logic.

Parameters:
- WIDTH, 32, input element width in bits; signed two's complement, same binary point as the output.
- ACC_WIDTH, 48, accumulator/output width in bits; must be >= WIDTH.
- LEN_WIDTH, 16, width of the vector-length field and the element counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset (assert async, release sync to clk upstream).
- cfg_len  in  LEN_WIDTH  elements per vector; sampled on the first accepted element of each vector.
- in_vld  in  1  input element valid.
- in_dat  in  WIDTH  signed input element.
- in_rdy  out  1  block can accept an element this cycle.
- out_vld  out  1  vector sum valid.
- out_dat  out  ACC_WIDTH  saturated signed vector sum.
- out_ovf  out  1  sticky: saturation occurred within this vector; qualified by out_vld.
- out_rdy  in  1  downstream accepts the sum.

Behaviour:
- Reset (async, rst_n=0): state=ACC, acc=0, cnt=0, len_q=0, out_vld=0, out_dat=0, out_ovf=0, in_rdy=1 after release.
- States: ACC (collecting) and HOLD (result presented).
- in_rdy = (state==ACC); combinational from state only, never from in_vld.
- Input handshake = in_vld && in_rdy. Data, cfg_len and in_dat are ignored when no handshake occurs.
- On a handshake with cnt==0: len_q <= (cfg_len==0 ? 1 : cfg_len); the effective length is computed from cfg_len in that same cycle.
- Each handshake: sum = acc + sign_extend(in_dat) computed at ACC_WIDTH+1 bits.
  - If the sum exceeds the signed ACC_WIDTH range, clamp to max positive or min negative and set the ovf sticky bit.
  - Subsequent additions continue from the clamped value.
- Last element: handshake with cnt == eff_len-1.
  - Next cycle: out_dat=final sum, out_ovf=sticky, out_vld=1, state=HOLD.
  - acc, cnt and sticky clear to 0 in the same edge.
  - Latency from last input handshake to out_vld = 1 cycle.
- Otherwise cnt <= cnt+1 and acc <= sum; no wrap is possible since eff_len <= 2^LEN_WIDTH-1.
- HOLD: out_vld, out_dat and out_ovf stay stable until out_rdy=1.
  - That edge: out_vld=0, state=ACC; out_dat holds its last value.
  - in_rdy stays 0 throughout HOLD, including the out_rdy cycle. One bubble per vector is the required throughput: max 1 vector per (len+1) cycles.
- out_rdy is ignored while out_vld=0.
- Single-element vector (cfg_len 0 or 1): the first handshake goes directly to HOLD.
- Reset mid-vector or in HOLD: partial sum and pending output are discarded; no output is produced.
- cfg_len changes mid-vector have no effect until the next vector's first element.

Decomposition:
- Package fixed_pkg: state enum (ACC, HOLD) and a function sat_add(acc, ext) returning {ovf, sum} for signed saturation at ACC_WIDTH.
- Package is shared with future fixed-point stream units.
- No sub-module; the FSM, counter and saturating adder are kept in one module.

Test Plan:
- cfg_len=4, in_dat 5,-3,10,1 with in_vld continuous -> in_rdy drops the cycle after the 4th handshake; out_dat=13, out_ovf=0, out_vld 1 cycle after the last handshake.
- Same vector with out_rdy=0 for 5 cycles -> out_dat and out_vld held stable, in_rdy=0 throughout; first new element accepted the cycle after out_rdy=1.
- WIDTH=32, ACC_WIDTH=32, cfg_len=3, in_dat 0x7FFFFFFF, 1, -1 -> out_dat=0x7FFFFFFE, out_ovf=1 (clamped at 0x7FFFFFFF, then minus 1).
- cfg_len=0, in_dat=-7 -> treated as length 1; out_dat=-7 sign-extended (0xFFFF_FFFF_FFF9 for 48 bits).
- cfg_len=3 then changed to 2 after the 1st element; send 1,2,3 -> out_dat=6, proving length sampling; the next vector uses length 2.
- rst_n pulsed low after 2 of 4 elements -> out_vld stays 0; a fresh vector 1,1,1,1 gives out_dat=4 with no residue from before reset.
